mc_ctrl: RTL and testbench

- Multi-cycle main controller for the MIPS-lite core.
- Sequences each instruction through FETCH/DCD/EXE/MEM/WB states and drives the register-file, memory and ALU enables and selects.
- Drives the next-PC select, with exactly one PC write per instruction on its final cycle.
- Sits between the instruction register fields and the existing next-PC, GRF, ALU, EXT and DM blocks.

---
 rtl/mc_ctrl_pkg.sv | 75 +++++++
 rtl/mc_ctrl_decode.sv | 33 +++
 rtl/mc_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mc_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller and the datapath
// blocks it steers (NPC, GRF write mux, ALU, EXT).
package mc_ctrl_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Controller states; values 9-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DCD    = 4'd1,
    ST_EXE    = 4'd2,
    ST_MEM_RD = 4'd3,
    ST_MEM_WR = 4'd4,
    ST_WB_ALU = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_JMP    = 4'd7,
    ST_JR     = 4'd8
  } state_e;

  // Next-PC select
  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JAL = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  // GRF destination select
  localparam logic [1:0] DST_RT  = 2'd0;
  localparam logic [1:0] DST_RD  = 2'd1;
  localparam logic [1:0] DST_RA  = 2'd2;

  // GRF write-data select
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DM   = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;

  // ALU operation
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_UPPER = 2'd2;

  // One-hot instruction class produced by mc_ctrl_decode
  typedef struct packed {
    logic is_addu;
    logic is_subu;
    logic is_jr;
    logic is_ori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bgtz;
    logic is_jal;
    logic is_illegal;
  } instr_class_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct to one-hot instruction-class decoder.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  // Exactly one class bit is set for any opcode/funct pair.
  always_comb begin
    cls = '0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU: cls.is_addu    = 1'b1;
          FN_SUBU: cls.is_subu    = 1'b1;
          FN_JR:   cls.is_jr      = 1'b1;
          default: cls.is_illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.is_ori     = 1'b1;
      OP_LUI:  cls.is_lui     = 1'b1;
      OP_LW:   cls.is_lw      = 1'b1;
      OP_SW:   cls.is_sw      = 1'b1;
      OP_BEQ:  cls.is_beq     = 1'b1;
      OP_BGTZ: cls.is_bgtz    = 1'b1;
      OP_JAL:  cls.is_jal     = 1'b1;
      default: cls.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences FETCH/DCD/EXE/MEM/WB and drives the
// datapath enables and selects. Exactly one pc_wr per instruction, on its
// final cycle (same cycle as instr_done).
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int PC_SEL_W = 2,
  parameter int ST_W     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                greater,
  output logic                pc_wr,
  output logic                ir_wr,
  output logic                reg_wr,
  output logic                mem_wr,
  output logic [PC_SEL_W-1:0] npc_sel,
  output logic [1:0]          reg_dst,
  output logic                alu_src,
  output logic [2:0]          alu_op,
  output logic [1:0]          ext_op,
  output logic [1:0]          wd_sel,
  output logic                instr_done,
  output logic                illegal,
  output logic [ST_W-1:0]     dbg_state
);

  state_e       state_q;
  state_e       state_d;
  instr_class_t cls;

  mc_ctrl_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  assign dbg_state = state_q;

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore/opcode output decode; all outputs held low in reset
  // because FETCH would otherwise assert ir_wr.
  always_comb begin
    state_d    = ST_FETCH;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    npc_sel    = NPC_PC4;
    reg_dst    = DST_RT;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = EXT_ZERO;
    wd_sel     = WD_ALU;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ir_wr   = 1'b1;
        state_d = ST_DCD;
      end

      ST_DCD: begin
        if (cls.is_illegal) begin
          // Unsupported instruction retires as a NOP.
          illegal    = 1'b1;
          pc_wr      = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (cls.is_jal) begin
          state_d = ST_JMP;
        end else if (cls.is_jr) begin
          state_d = ST_JR;
        end else begin
          state_d = ST_EXE;
        end
      end

      ST_EXE: begin
        if (cls.is_subu || cls.is_beq) alu_op = ALU_SUB;
        if (cls.is_ori) begin
          alu_op  = ALU_OR;
          alu_src = 1'b1;
          ext_op  = EXT_ZERO;
        end
        if (cls.is_lui) begin
          alu_op  = ALU_LUI;
          alu_src = 1'b1;
          ext_op  = EXT_UPPER;
        end
        if (cls.is_lw || cls.is_sw) begin
          alu_op  = ALU_ADD;
          alu_src = 1'b1;
          ext_op  = EXT_SIGN;
        end

        if (cls.is_beq || cls.is_bgtz) begin
          pc_wr      = 1'b1;
          instr_done = 1'b1;
          if ((cls.is_beq && zero) || (cls.is_bgtz && greater))
            npc_sel = NPC_BR;
          state_d = ST_FETCH;
        end else if (cls.is_addu || cls.is_subu || cls.is_ori || cls.is_lui) begin
          state_d = ST_WB_ALU;
        end else if (cls.is_lw) begin
          state_d = ST_MEM_RD;
        end else if (cls.is_sw) begin
          state_d = ST_MEM_WR;
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_MEM_RD: begin
        // ALU output register keeps the address; DM read in flight.
        state_d = ST_WB_MEM;
      end

      ST_MEM_WR: begin
        mem_wr     = 1'b1;
        pc_wr      = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_WB_ALU: begin
        reg_wr     = 1'b1;
        reg_dst    = (cls.is_addu || cls.is_subu) ? DST_RD : DST_RT;
        wd_sel     = WD_ALU;
        pc_wr      = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_WB_MEM: begin
        reg_wr     = 1'b1;
        reg_dst    = DST_RT;
        wd_sel     = WD_DM;
        pc_wr      = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_JMP: begin
        reg_wr     = 1'b1;
        reg_dst    = DST_RA;
        wd_sel     = WD_PC4;
        pc_wr      = 1'b1;
        npc_sel    = NPC_JAL;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_JR: begin
        pc_wr      = 1'b1;
        npc_sel    = NPC_JR;
        instr_done = 1'b1;
        state_d    = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    if (reset) begin
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_wr     = 1'b0;
      npc_sel    = NPC_PC4;
      reg_dst    = DST_RT;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      ext_op     = EXT_ZERO;
      wd_sel     = WD_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed instruction sequence followed by random
// instructions, every cycle compared against an instruction-level trace model.
module tb_mc_ctrl;

  localparam int W = 22;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode, funct;
  logic       zero, greater;
  logic       pc_wr, ir_wr, reg_wr, mem_wr, alu_src, instr_done, illegal;
  logic [1:0] npc_sel, reg_dst, ext_op, wd_sel;
  logic [2:0] alu_op;
  logic [3:0] dbg_state;

  mc_ctrl #(.PC_SEL_W(2), .ST_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .greater    (greater),
    .pc_wr      (pc_wr),
    .ir_wr      (ir_wr),
    .reg_wr     (reg_wr),
    .mem_wr     (mem_wr),
    .npc_sel    (npc_sel),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .ext_op     (ext_op),
    .wd_sel     (wd_sel),
    .instr_done (instr_done),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] observed();
    return {dbg_state, illegal, instr_done, wd_sel, ext_op, alu_op, alu_src,
            reg_dst, npc_sel, mem_wr, reg_wr, ir_wr, pc_wr};
  endfunction

  // One expected cycle; pc_wr/instr_done are a single "retire" flag.
  function automatic logic [W-1:0] cyc(input int st, input bit ir, input bit retire,
                                       input bit rw, input bit mw, input int npc,
                                       input int dst, input bit asrc, input int aop,
                                       input int ext, input int wd, input bit ill);
    logic [3:0] s; logic [1:0] n, d, e, w; logic [2:0] a;
    s = st[3:0]; n = npc[1:0]; d = dst[1:0]; a = aop[2:0]; e = ext[1:0]; w = wd[1:0];
    return {s, ill, retire, w, e, a, asrc, d, n, mw, rw, ir, retire};
  endfunction

  // Instruction-level reference: the complete cycle trace one instruction
  // must produce, from its class and the branch flags.
  task automatic model(input logic [5:0] op, input logic [5:0] fn,
                       input bit z, input bit g);
    bit r_addu, r_subu, r_jr, legal, taken;
    int aop, ext; bit asrc;
    r_addu = (op == 6'b000000) && (fn == 6'b100001);
    r_subu = (op == 6'b000000) && (fn == 6'b100011);
    r_jr   = (op == 6'b000000) && (fn == 6'b001000);
    legal  = r_addu || r_subu || r_jr ||
             op inside {6'b001101, 6'b001111, 6'b100011, 6'b101011,
                        6'b000100, 6'b000111, 6'b000011};
    exp_q.push_back(cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (!legal) begin
      exp_q.push_back(cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      return;
    end
    exp_q.push_back(cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (op == 6'b000011) begin
      exp_q.push_back(cyc(7, 0, 1, 1, 0, 2, 2, 0, 0, 0, 2, 0));
      return;
    end
    if (r_jr) begin
      exp_q.push_back(cyc(8, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0));
      return;
    end
    aop = 0; asrc = 0; ext = 0;
    if (r_subu || op == 6'b000100) aop = 1;
    if (op == 6'b001101) begin aop = 2; asrc = 1; ext = 0; end
    if (op == 6'b001111) begin aop = 3; asrc = 1; ext = 2; end
    if (op == 6'b100011 || op == 6'b101011) begin aop = 0; asrc = 1; ext = 1; end
    if (op == 6'b000100 || op == 6'b000111) begin
      taken = (op == 6'b000100) ? z : g;
      exp_q.push_back(cyc(2, 0, 1, 0, 0, taken ? 1 : 0, 0, asrc, aop, ext, 0, 0));
      return;
    end
    exp_q.push_back(cyc(2, 0, 0, 0, 0, 0, 0, asrc, aop, ext, 0, 0));
    if (op == 6'b100011) begin
      exp_q.push_back(cyc(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(cyc(6, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    end else if (op == 6'b101011) begin
      exp_q.push_back(cyc(4, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      exp_q.push_back(cyc(5, 0, 1, 1, 0, 0, (op == 6'b000000) ? 1 : 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = observed();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    total++;
    assert (pc_wr === instr_done && !(reg_wr && mem_wr)) else begin
      bad++;
      $error("FAIL %s_invariant: pc_wr=%b instr_done=%b reg_wr=%b mem_wr=%b",
             tag, pc_wr, instr_done, reg_wr, mem_wr);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a negedge with the DUT in FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input bit g);
    opcode = op; funct = fn; zero = z; greater = g;
    model(op, fn, z, g);
    while (exp_q.size() > 0) begin
      #1 check(tag, exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  logic [5:0] legal_op[10];
  logic [5:0] legal_fn[10];

  initial begin
    logic [5:0] op, fn;
    opcode = '0; funct = '0; zero = 1'b0; greater = 1'b0;
    legal_op = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                 6'b100011, 6'b101011, 6'b000100, 6'b000111, 6'b000011};
    legal_fn = '{6'b100001, 6'b100011, 6'b001000, 6'b000000, 6'b000000,
                 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};

    // Reset held for 3 cycles: everything low, state FETCH.
    repeat (3) begin
      @(negedge clk);
      #1 check("reset", '0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Directed sequence
    run_instr("addu",     6'b000000, 6'b100001, 0, 0);
    run_instr("lw",       6'b100011, 6'b010101, 0, 0);
    run_instr("sw",       6'b101011, 6'b000000, 1, 1);
    run_instr("beq_t",    6'b000100, 6'b000000, 1, 0);
    run_instr("beq_nt",   6'b000100, 6'b000000, 0, 1);
    run_instr("bgtz_t",   6'b000111, 6'b000000, 0, 1);
    run_instr("bgtz_nt",  6'b000111, 6'b000000, 1, 0);
    run_instr("jal",      6'b000011, 6'b000000, 0, 0);
    run_instr("jr",       6'b000000, 6'b001000, 0, 0);
    run_instr("subu",     6'b000000, 6'b100011, 0, 0);
    run_instr("ori",      6'b001101, 6'b100001, 0, 0);
    run_instr("lui",      6'b001111, 6'b000000, 0, 0);
    run_instr("illegal",  6'b111111, 6'b000000, 0, 0);
    run_instr("bad_fn",   6'b000000, 6'b111111, 0, 0);

    // lw interrupted by reset while in MEM_RD
    opcode = 6'b100011; funct = '0; zero = 0; greater = 0;
    model(6'b100011, 6'b000000, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1 check("lw_pre_rst", exp_q.pop_front());
      if (i < 3) @(negedge clk);
    end
    exp_q.delete();
    reset = 1'b1;
    #1 check("mid_rst", '0);
    @(negedge clk);
    #1 check("mid_rst_hold", '0);
    reset = 1'b0;
    run_instr("after_rst", 6'b001101, 6'b000000, 0, 0);

    // Randomized instructions: half from the legal set, half fully random.
    for (int k = 0; k < 60; k++) begin
      int idx;
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, 9);
        op = legal_op[idx];
        fn = legal_fn[idx];
        if (op != 6'b000000) fn = 6'($urandom_range(0, 63));
      end else begin
        op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end
      run_instr("random", op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
